// File: rtl/am_demod_gen_if.sv
// am_demod_gen_if: sample/config inputs and result outputs of the AM demodulator.
// master drives samples and config, slave is the demodulator.
interface am_demod_gen_if #(
  parameter int DW = 8,
  parameter int LW = 16,
  parameter int RW = 16,
  parameter int OW = 18
);
  logic                 in_valid;
  logic signed [DW-1:0] adc_data;
  logic signed [LW-1:0] lo_cos;
  logic signed [LW-1:0] lo_sin;
  logic [RW-1:0]        dec_ratio;
  logic [1:0]           mode;
  logic [5:0]           out_shift;
  logic signed [OW-1:0] out_data;
  logic                 out_valid;
  logic                 sat_flag;

  modport master (
    output in_valid,
    output adc_data,
    output lo_cos,
    output lo_sin,
    output dec_ratio,
    output mode,
    output out_shift,
    input  out_data,
    input  out_valid,
    input  sat_flag
  );

  modport slave (
    input  in_valid,
    input  adc_data,
    input  lo_cos,
    input  lo_sin,
    input  dec_ratio,
    input  mode,
    input  out_shift,
    output out_data,
    output out_valid,
    output sat_flag
  );
endinterface

// File: rtl/am_demod_gen.sv
// am_demod_gen: I/Q mixer, CIC decimator, scaling and magnitude stage.
// Six registered stages, no backpressure, frame config latched per frame.
module am_demod_gen #(
  parameter int DW    = 8,
  parameter int LW    = 16,
  parameter int CIC_N = 3,
  parameter int ACC_W = 42,
  parameter int RW    = 16,
  parameter int OW    = 18
) (
  input logic           clk,
  input logic           rst_n,
  am_demod_gen_if.slave bus
);
  localparam int PW = DW + LW;

  typedef struct packed {
    logic [RW-1:0] ratio;
    logic [1:0]    mode;
    logic [5:0]    shift;
  } cfg_t;

  typedef logic signed [ACC_W-1:0] acc_t;

  localparam acc_t MAXA = acc_t'({1'b0, {(OW-1){1'b1}}});
  localparam acc_t MINA = ~MAXA;
  localparam logic signed [OW-1:0] MAXO = {1'b0, {(OW-1){1'b1}}};
  localparam logic signed [OW-1:0] MINO = ~MAXO;

  function automatic logic [OW:0] clamp(input acc_t v);
    logic [OW:0] r;
    if (v > MAXA) r = {1'b1, MAXO};
    else if (v < MINA) r = {1'b1, MINO};
    else r = {1'b0, v[OW-1:0]};
    return r;
  endfunction

  function automatic logic [OW-1:0] mag(input logic signed [OW-1:0] v);
    logic [OW-1:0] r;
    if (v == MINO) r = MAXO;
    else if (v[OW-1]) r = -v;
    else r = v;
    return r;
  endfunction

  // S1: mixer
  logic                 s1_vld_q;
  logic signed [PW-1:0] s1_i_q;
  logic signed [PW-1:0] s1_q_q;
  cfg_t                 s1_cfg_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_vld_q <= 1'b0;
      s1_i_q   <= '0;
      s1_q_q   <= '0;
      s1_cfg_q <= '0;
    end else begin
      s1_vld_q <= bus.in_valid;
      if (bus.in_valid) begin
        s1_i_q   <= PW'(bus.adc_data) * PW'(bus.lo_cos);
        s1_q_q   <= PW'(bus.lo_sin) * PW'(bus.adc_data);
        s1_cfg_q <= '{ratio: bus.dec_ratio,
                      mode:  bus.mode,
                      shift: bus.out_shift};
      end
    end
  end

  // S2: floor truncation back to DW bits
  logic                 s2_vld_q;
  logic signed [DW-1:0] s2_i_q;
  logic signed [DW-1:0] s2_q_q;
  cfg_t                 s2_cfg_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s2_vld_q <= 1'b0;
      s2_i_q   <= '0;
      s2_q_q   <= '0;
      s2_cfg_q <= '0;
    end else begin
      s2_vld_q <= s1_vld_q;
      if (s1_vld_q) begin
        s2_i_q   <= DW'(s1_i_q >>> (LW-1));
        s2_q_q   <= DW'(s1_q_q >>> (LW-1));
        s2_cfg_q <= s1_cfg_q;
      end
    end
  end

  // S3: integrators and frame counter
  acc_t          ii_q [CIC_N];
  acc_t          iq_q [CIC_N];
  acc_t          ii_d [CIC_N];
  acc_t          iq_d [CIC_N];
  acc_t          ci;
  acc_t          cq;
  logic [RW-1:0] cnt_q;
  logic [RW-1:0] cnt_d;
  logic [RW-1:0] rm1;
  cfg_t          fcfg_q;
  cfg_t          fcfg_d;
  cfg_t          cfg_now;
  logic          last;
  logic          s3_end_q;
  logic [1:0]    s3_mode_q;
  logic [5:0]    s3_shift_q;

  always_comb begin
    ii_d    = ii_q;
    iq_d    = iq_q;
    ci      = acc_t'(s2_i_q);
    cq      = acc_t'(s2_q_q);
    cfg_now = (cnt_q == '0) ? s2_cfg_q : fcfg_q;
    rm1     = (cfg_now.ratio <= RW'(1)) ? '0
                                        : cfg_now.ratio - RW'(1);
    last    = (cnt_q == rm1);
    cnt_d   = cnt_q;
    fcfg_d  = fcfg_q;
    if (s2_vld_q) begin
      for (int k = 0; k < CIC_N; k++) begin
        ii_d[k] = ii_q[k] + ci;
        iq_d[k] = iq_q[k] + cq;
        ci      = ii_d[k];
        cq      = iq_d[k];
      end
      cnt_d  = last ? '0 : cnt_q + RW'(1);
      fcfg_d = cfg_now;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < CIC_N; k++) begin
        ii_q[k] <= '0;
        iq_q[k] <= '0;
      end
      cnt_q      <= '0;
      fcfg_q     <= '0;
      s3_end_q   <= 1'b0;
      s3_mode_q  <= '0;
      s3_shift_q <= '0;
    end else begin
      ii_q     <= ii_d;
      iq_q     <= iq_d;
      cnt_q    <= cnt_d;
      fcfg_q   <= fcfg_d;
      s3_end_q <= s2_vld_q & last;
      if (s2_vld_q & last) begin
        s3_mode_q  <= cfg_now.mode;
        s3_shift_q <= cfg_now.shift;
      end
    end
  end

  // S4: combs, evaluated once per frame
  acc_t       di_q [CIC_N];
  acc_t       dq_q [CIC_N];
  acc_t       di_d [CIC_N];
  acc_t       dq_d [CIC_N];
  acc_t       yi;
  acc_t       yq;
  logic       s4_vld_q;
  acc_t       s4_i_q;
  acc_t       s4_q_q;
  logic [1:0] s4_mode_q;
  logic [5:0] s4_shift_q;

  always_comb begin
    di_d = di_q;
    dq_d = dq_q;
    yi   = ii_q[CIC_N-1];
    yq   = iq_q[CIC_N-1];
    if (s3_end_q) begin
      for (int k = 0; k < CIC_N; k++) begin
        di_d[k] = yi;
        dq_d[k] = yq;
        yi      = yi - di_q[k];
        yq      = yq - dq_q[k];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < CIC_N; k++) begin
        di_q[k] <= '0;
        dq_q[k] <= '0;
      end
      s4_vld_q   <= 1'b0;
      s4_i_q     <= '0;
      s4_q_q     <= '0;
      s4_mode_q  <= '0;
      s4_shift_q <= '0;
    end else begin
      di_q     <= di_d;
      dq_q     <= dq_d;
      s4_vld_q <= s3_end_q;
      if (s3_end_q) begin
        s4_i_q     <= yi;
        s4_q_q     <= yq;
        s4_mode_q  <= s3_mode_q;
        s4_shift_q <= s3_shift_q;
      end
    end
  end

  // S5: gain shift and saturation
  acc_t                 sh_i;
  acc_t                 sh_q;
  logic [OW:0]          cl_i;
  logic [OW:0]          cl_q;
  logic                 s5_vld_q;
  logic signed [OW-1:0] s5_i_q;
  logic signed [OW-1:0] s5_q_q;
  logic [1:0]           s5_mode_q;
  logic                 sat_q;

  always_comb begin
    sh_i = s4_i_q >>> s4_shift_q;
    sh_q = s4_q_q >>> s4_shift_q;
    cl_i = clamp(sh_i);
    cl_q = clamp(sh_q);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s5_vld_q  <= 1'b0;
      s5_i_q    <= '0;
      s5_q_q    <= '0;
      s5_mode_q <= '0;
      sat_q     <= 1'b0;
    end else begin
      s5_vld_q <= s4_vld_q;
      if (s4_vld_q) begin
        s5_i_q    <= cl_i[OW-1:0];
        s5_q_q    <= cl_q[OW-1:0];
        s5_mode_q <= s4_mode_q;
        sat_q     <= sat_q | cl_i[OW] | cl_q[OW];
      end
    end
  end

  // S6: output select / magnitude estimates
  logic [OW-1:0]        ai;
  logic [OW-1:0]        aq;
  logic [OW-1:0]        mx;
  logic [OW-1:0]        mn;
  logic [2*OW-1:0]      si;
  logic [2*OW-1:0]      sq;
  logic [2*OW:0]        pw;
  logic [2*OW:0]        pws;
  logic [OW:0]          am;
  logic signed [OW-1:0] res;
  logic signed [OW-1:0] out_q;
  logic                 ov_q;

  always_comb begin
    ai  = mag(s5_i_q);
    aq  = mag(s5_q_q);
    mx  = (ai > aq) ? ai : aq;
    mn  = (ai > aq) ? aq : ai;
    si  = {{OW{1'b0}}, ai} * {{OW{1'b0}}, ai};
    sq  = {{OW{1'b0}}, aq} * {{OW{1'b0}}, aq};
    pw  = {1'b0, si} + {1'b0, sq};
    pws = pw >> (OW-1);
    am  = {1'b0, mx} + {1'b0, mn >> 1};
    res = '0;
    unique case (s5_mode_q)
      2'd0: res = s5_i_q;
      2'd1: res = s5_q_q;
      2'd2: res = (|pws[2*OW:OW-1]) ? MAXO
                                    : {1'b0, pws[OW-2:0]};
      2'd3: res = (|am[OW:OW-1]) ? MAXO
                                 : {1'b0, am[OW-2:0]};
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_q <= '0;
      ov_q  <= 1'b0;
    end else begin
      ov_q <= s5_vld_q;
      if (s5_vld_q) out_q <= res;
    end
  end

  assign bus.out_data  = out_q;
  assign bus.out_valid = ov_q;
  assign bus.sat_flag  = sat_q;
endmodule

// File: tb/tb_am_demod_gen.sv
// tb_am_demod_gen: directed stimulus, expected results queued per frame
// and popped by a monitor on every out_valid.
module tb_am_demod_gen;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic               iv;
  logic               selb;
  logic signed [7:0]  adc;
  logic signed [15:0] lo_cos;
  logic signed [15:0] lo_sin;
  logic [15:0]        dec;
  logic [1:0]         mode;
  logic [5:0]         shift;

  am_demod_gen_if #(.DW(8), .LW(16), .RW(16), .OW(18)) ia ();
  am_demod_gen_if #(.DW(8), .LW(16), .RW(16), .OW(18)) ib ();

  assign ia.in_valid  = iv & ~selb;
  assign ia.adc_data  = adc;
  assign ia.lo_cos    = lo_cos;
  assign ia.lo_sin    = lo_sin;
  assign ia.dec_ratio = dec;
  assign ia.mode      = mode;
  assign ia.out_shift = shift;
  assign ib.in_valid  = iv & selb;
  assign ib.adc_data  = adc;
  assign ib.lo_cos    = lo_cos;
  assign ib.lo_sin    = lo_sin;
  assign ib.dec_ratio = dec;
  assign ib.mode      = mode;
  assign ib.out_shift = shift;

  am_demod_gen ua (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ia)
  );

  am_demod_gen #(.CIC_N(1), .ACC_W(24)) ub (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ib)
  );

  typedef struct {
    int cyc;
    bit chk;
    int val;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  exp_t ea;
  exp_t eb;
  int   checks = 0;
  int   failures = 0;
  int   cnt_a = 0;
  int   cnt_b = 0;
  int   reff_a = 1;
  int   reff_b = 1;

  task automatic chk(input string nm, input int got, input int want);
    checks++;
    if (got != want) begin
      failures++;
      $display("FAIL %s got=%0d want=%0d cyc=%0d", nm, got, want, cyc);
    end
  endtask

  // ev/c apply only if this sample closes a frame
  task automatic send(input int a, input int ev, input bit c);
    exp_t e;
    adc = 8'(a);
    iv  = 1'b1;
    e.cyc = cyc + 6;
    e.chk = c;
    e.val = ev;
    if (!selb) begin
      if (cnt_a == 0) reff_a = (dec <= 1) ? 1 : int'(dec);
      cnt_a++;
      if (cnt_a == reff_a) begin
        qa.push_back(e);
        cnt_a = 0;
      end
    end else begin
      if (cnt_b == 0) reff_b = (dec <= 1) ? 1 : int'(dec);
      cnt_b++;
      if (cnt_b == reff_b) begin
        qb.push_back(e);
        cnt_b = 0;
      end
    end
    @(posedge clk);
    #1;
    iv = 1'b0;
  endtask

  task automatic idle(input int n);
    iv = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    iv    = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    qa.delete();
    qb.delete();
    cnt_a = 0;
    cnt_b = 0;
  endtask

  always @(negedge clk) begin
    if (ia.out_valid) begin
      if (qa.size() == 0) chk("a_unexpected_valid", 1, 0);
      else begin
        ea = qa.pop_front();
        chk("a_latency", cyc, ea.cyc);
        if (ea.chk) chk("a_out_data", ia.out_data, ea.val);
      end
    end
  end

  always @(negedge clk) begin
    if (ib.out_valid) begin
      if (qb.size() == 0) chk("b_unexpected_valid", 1, 0);
      else begin
        eb = qb.pop_front();
        chk("b_latency", cyc, eb.cyc);
        if (eb.chk) chk("b_out_data", ib.out_data, eb.val);
      end
    end
  end

  initial begin
    int ev;
    iv     = 1'b0;
    selb   = 1'b0;
    adc    = '0;
    lo_cos = 16'sd32767;
    lo_sin = 16'sd0;
    dec    = 16'd4;
    mode   = 2'd0;
    shift  = 6'd0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("rst_out_data", ia.out_data, 0);
    chk("rst_out_valid", ia.out_valid, 0);
    chk("rst_sat_flag", ia.sat_flag, 0);
    chk("rst_b_out_data", ib.out_data, 0);

    // R=4, I only; mode switches land on the following frame
    for (int f = 1; f <= 8; f++) begin
      for (int s = 0; s < 4; s++) begin
        if (f == 5 && s == 2) mode = 2'd2;
        if (f == 7 && s == 2) mode = 2'd3;
        ev = (f == 6 || f == 7) ? 124 : 4032;
        send(64, ev, f >= 4);
        if (f == 3 && s == 1) idle(3);
      end
    end
    idle(8);
    chk("a_hold", ia.out_data, 4032);
    chk("a_no_sat", ia.sat_flag, 0);

    // I=63, Q=-64: modes 1,2,3 and a shift change
    do_reset();
    lo_sin = -16'sd32768;
    mode   = 2'd1;
    for (int f = 1; f <= 10; f++) begin
      for (int s = 0; s < 4; s++) begin
        if (f == 5 && s == 2) mode = 2'd2;
        if (f == 7 && s == 2) mode = 2'd3;
        if (f == 9 && s == 2) begin
          mode  = 2'd1;
          shift = 6'd2;
        end
        case (f)
          6, 7:    ev = 252;
          8, 9:    ev = 6112;
          10:      ev = -1024;
          default: ev = -4096;
        endcase
        send(64, ev, f >= 4);
      end
    end
    idle(8);

    // saturation, sticky until reset
    do_reset();
    lo_sin = 16'sd0;
    mode   = 2'd0;
    shift  = 6'd0;
    dec    = 16'd125;
    for (int f = 1; f <= 2; f++)
      for (int s = 0; s < 125; s++) send(127, 131071, 1'b1);
    idle(8);
    chk("sat_set", ia.sat_flag, 1);
    for (int f = 1; f <= 4; f++)
      for (int s = 0; s < 125; s++) send(0, 0, f >= 3);
    idle(8);
    chk("sat_sticky", ia.sat_flag, 1);
    do_reset();
    chk("sat_cleared", ia.sat_flag, 0);
    chk("sat_rst_data", ia.out_data, 0);

    // CIC_N=1, R_eff=1 for dec 0 and 1, gaps mirrored
    selb = 1'b1;
    dec  = 16'd0;
    send(-128, -128, 1'b1);
    send(-128, -128, 1'b1);
    idle(2);
    send(-128, -128, 1'b1);
    send(100, 99, 1'b1);
    send(5, 4, 1'b1);
    send(-1, -1, 1'b1);
    dec = 16'd1;
    send(-128, -128, 1'b1);
    idle(3);
    send(-128, -128, 1'b1);
    send(-128, -128, 1'b1);
    idle(1);
    send(-128, -128, 1'b1);
    idle(8);
    selb = 1'b0;

    // reset discards in-flight and partial frames
    dec = 16'd4;
    do_reset();
    for (int s = 0; s < 4; s++) send(64, 0, 1'b0);
    do_reset();
    idle(10);
    send(64, 0, 1'b0);
    send(64, 0, 1'b0);
    do_reset();
    idle(6);
    for (int s = 0; s < 4; s++) send(64, 0, 1'b0);
    idle(10);

    chk("qa_drained", qa.size(), 0);
    chk("qb_drained", qb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
